// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing one memory port between requesters A and B.
// Grant is combinational; read data returns 2 cycles after grant. Optional stall counters under ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] di_a,
  output logic                  gnt_a,
  output logic [DATA_WIDTH-1:0] do_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] di_b,
  output logic                  gnt_b,
  output logic [DATA_WIDTH-1:0] do_b,
  output logic                  rvalid_b,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do,
  output logic [15:0]           wait_cnt_a,
  output logic [15:0]           wait_cnt_b
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  last_b_q, last_b_d;
  logic                  rd_pend_a_q, rd_pend_a_d, rd_pend_b_q, rd_pend_b_d;
  logic                  rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_WIDTH-1:0] do_a_q, do_a_d, do_b_q, do_b_d;
  logic                  ra, rb;

  // Requests are masked during reset so nothing reaches the memory.
  assign ra = req_a & ~rst;
  assign rb = req_b & ~rst;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ra && (!rb || last_b_q)) begin
          gnt_a = 1'b1; state_d = OWN_A; burst_cnt_d = '0;
        end else if (rb) begin
          gnt_b = 1'b1; state_d = OWN_B; burst_cnt_d = '0;
        end
      end
      OWN_A: begin
        if (ra && (!rb || burst_cnt_q < BURST_LAST)) begin
          gnt_a = 1'b1;
          if (burst_cnt_q < BURST_LAST) burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (rb) begin
          gnt_b = 1'b1; state_d = OWN_B; burst_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_B: begin
        if (rb && (!ra || burst_cnt_q < BURST_LAST)) begin
          gnt_b = 1'b1;
          if (burst_cnt_q < BURST_LAST) burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (ra) begin
          gnt_a = 1'b1; state_d = OWN_A; burst_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    last_b_d = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_b_q);

    // Read return: mem_do is valid the cycle after grant, captured one cycle later.
    rd_pend_a_d = gnt_a & ~we_a;
    rd_pend_b_d = gnt_b & ~we_b;
    rvalid_a_d  = rd_pend_a_q;
    rvalid_b_d  = rd_pend_b_q;
    do_a_d      = rd_pend_a_q ? mem_do : do_a_q;
    do_b_d      = rd_pend_b_q ? mem_do : do_b_q;
  end

  assign mem_en   = gnt_a | gnt_b;
  assign mem_we   = (gnt_a & we_a) | (gnt_b & we_b);
  assign mem_addr = gnt_b ? addr_b : addr_a;
  assign mem_di   = gnt_b ? di_b : di_a;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign do_a     = do_a_q;
  assign do_b     = do_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_b_q    <= 1'b1;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      do_a_q      <= '0;
      do_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_b_q    <= last_b_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      do_a_q      <= do_a_d;
      do_b_q      <= do_b_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] wait_cnt_a_q, wait_cnt_a_d, wait_cnt_b_q, wait_cnt_b_d;

  always_comb begin
    wait_cnt_a_d = wait_cnt_a_q;
    wait_cnt_b_d = wait_cnt_b_q;
    if (ra && !gnt_a && wait_cnt_a_q != 16'hFFFF) wait_cnt_a_d = wait_cnt_a_q + 16'd1;
    if (rb && !gnt_b && wait_cnt_b_q != 16'hFFFF) wait_cnt_b_d = wait_cnt_b_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_a_q <= '0;
      wait_cnt_b_q <= '0;
    end else begin
      wait_cnt_a_q <= wait_cnt_a_d;
      wait_cnt_b_q <= wait_cnt_b_d;
    end
  end

  assign wait_cnt_a = wait_cnt_a_q;
  assign wait_cnt_b = wait_cnt_b_q;
`else
  assign wait_cnt_a = 16'd0;
  assign wait_cnt_b = 16'd0;
`endif

endmodule
